// File: rtl/blink_round_ctrl.sv
// Round controller for the BLINK block cipher: sequences ROUNDS passes through an external
// MixColumns_AddKey stage. Optional key whitening on load: define BLINK_ROUND_CTRL_WHITEN_EN.
module blink_round_ctrl #(
  parameter int ROUNDS = 16,
  parameter int RK_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     in_data,
  output logic [RK_W-1:0] rk_idx,
  input  logic [63:0]     rk_data,
  output logic [63:0]     mc_in,
  output logic [63:0]     mc_key,
  input  logic [63:0]     mc_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     out_data,
  output logic            busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [RK_W-1:0] LAST_RND = RK_W'(ROUNDS - 1);

`ifdef BLINK_ROUND_CTRL_WHITEN_EN
  // Key 0 is consumed by the whitening XOR at load, so the rounds start at key 1.
  localparam logic [RK_W-1:0] BASE = RK_W'(1);
`else
  localparam logic [RK_W-1:0] BASE = RK_W'(0);
`endif

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [RK_W-1:0] rnd;
  logic [63:0]     state_reg;
  logic [63:0]     load_data;
  logic            accept;

  // in_ready depends only on state, clear and out_ready, never on in_valid.
  assign in_ready  = ~clear & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign rk_idx    = (state == RUN) ? rnd + BASE : '0;
  assign mc_in     = state_reg;
  assign mc_key    = rk_data;
  assign out_valid = (state == DONE);
  assign out_data  = state_reg;
  assign busy      = (state == RUN);

`ifdef BLINK_ROUND_CTRL_WHITEN_EN
  assign load_data = in_data ^ rk_data;
`else
  assign load_data = in_data;
`endif

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = RUN;
        RUN:  if (rnd == LAST_RND) state_nxt = DONE;
        DONE: begin
          if (accept) state_nxt = RUN;
          else if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= '0;
      state_reg <= '0;
    end else begin
      state <= state_nxt;
      // The counter parks at 0 outside RUN so it can never run past the last round.
      if (clear || accept) begin
        rnd <= '0;
      end else if (state == RUN) begin
        rnd <= (rnd == LAST_RND) ? '0 : rnd + 1'b1;
      end
      if (!clear) begin
        if (accept) begin
          state_reg <= load_data;
        end else if (state == RUN) begin
          state_reg <= mc_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_blink_round_ctrl.sv
// Directed testbench for blink_round_ctrl: a ROUNDS=16 instance with an increment stub for
// MixColumns_AddKey, plus a ROUNDS=2 instance with an all-zero datapath.
module tb_blink_round_ctrl;

  localparam logic [63:0] KEY_HI = 64'hA5A5_0000_0000_0000;
`ifdef BLINK_ROUND_CTRL_WHITEN_EN
  localparam int BASE = 1;
`else
  localparam int BASE = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear, in_valid, out_ready;
  logic [63:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [4:0]  rk_idx;
  logic [63:0] rk_data, mc_in, mc_key, mc_out, out_data;

  logic        clear2, in_valid2, out_ready2;
  logic [63:0] in_data2;
  logic        in_ready2, out_valid2, busy2;
  logic [1:0]  rk_idx2;
  logic [63:0] rk_data2, mc_in2, mc_key2, mc_out2, out_data2;

  int total = 0;
  int bad   = 0;

  // Key ROM model and round stub: each round adds 1, ignoring the key.
  assign rk_data  = KEY_HI | {59'd0, rk_idx};
  assign mc_out   = mc_in + 64'd1;
  assign rk_data2 = 64'd0;
  assign mc_out2  = mc_in2 ^ mc_key2;

  blink_round_ctrl #(.ROUNDS(16), .RK_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data), .mc_in(mc_in), .mc_key(mc_key),
    .mc_out(mc_out), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  blink_round_ctrl #(.ROUNDS(2), .RK_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .rk_idx(rk_idx2), .rk_data(rk_data2), .mc_in(mc_in2), .mc_key(mc_key2),
    .mc_out(mc_out2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .busy(busy2)
  );

  function automatic logic [63:0] loadVal(input logic [63:0] d);
`ifdef BLINK_ROUND_CTRL_WHITEN_EN
    return d ^ KEY_HI;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy,
                               input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [63:0] d;
    logic        seen;

    rst_n = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    clear2 = 1'b0; in_valid2 = 1'b0; in_data2 = 64'd0; out_ready2 = 1'b0;
    tick(); tick();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_mc_in", mc_in, 64'd0);
    checkOutput("rst_rk_idx", 64'(rk_idx), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    $display("[TB] ROUNDS=2 zero block latency");
    in_valid2 = 1'b1;
    #1;
    checkOutput("r2_in_ready", 64'(in_ready2), 64'd1);
    tick();
    in_valid2 = 1'b0;
    checkOutput("r2_cyc1_valid", 64'(out_valid2), 64'd0);
    tick();
    checkOutput("r2_cyc2_valid", 64'(out_valid2), 64'd0);
    tick();
    checkOutput("r2_cyc3_valid", 64'(out_valid2), 64'd1);
    checkOutput("r2_out_data", out_data2, 64'd0);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    checkOutput("r2_drained", 64'(out_valid2), 64'd0);

    $display("[TB] ROUNDS=16 key index sequence");
    d = 64'h0123_4567_89AB_CDEF;
    applyStimulus(1'b1, d, 1'b0, 1'b0);
    #1;
    checkOutput("acc_rk_idx", 64'(rk_idx), 64'd0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("run_busy", 64'(busy), 64'd1);
      checkOutput("run_rk_idx", 64'(rk_idx), 64'(i + BASE));
      checkOutput("run_mc_key", mc_key, KEY_HI | 64'(i + BASE));
      checkOutput("run_mc_in", mc_in, loadVal(d) + 64'(i));
      tick();
    end
    checkOutput("done_valid", 64'(out_valid), 64'd1);
    checkOutput("done_data", out_data, loadVal(d) + 64'd16);
    checkOutput("done_busy", 64'(busy), 64'd0);

    $display("[TB] backpressure in DONE");
    applyStimulus(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_data", out_data, loadVal(d) + 64'd16);
    end
    checkOutput("hold_not_busy", 64'(busy), 64'd0);

    $display("[TB] back-to-back accept from DONE");
    d = 64'h1111_2222_3333_4444;
    applyStimulus(1'b1, d, 1'b1, 1'b0);
    #1;
    checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    checkOutput("b2b_valid", 64'(out_valid), 64'd0);
    checkOutput("b2b_mc_in", mc_in, loadVal(d));
    for (int i = 0; i < 15; i++) tick();
    checkOutput("b2b_last_rk", 64'(rk_idx), 64'(15 + BASE));
    checkOutput("b2b_early_valid", 64'(out_valid), 64'd0);
    tick();
    checkOutput("b2b_done_valid", 64'(out_valid), 64'd1);
    checkOutput("b2b_done_data", out_data, loadVal(d) + 64'd16);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    checkOutput("drain_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] clear mid-run");
    applyStimulus(1'b1, 64'h5555_0000_AAAA_0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("clr_rk_idx", 64'(rk_idx), 64'(7 + BASE));
    applyStimulus(1'b1, 64'h7777_7777_7777_7777, 1'b0, 1'b1);
    tick();
    checkOutput("clr_busy", 64'(busy), 64'd0);
    checkOutput("clr_valid", 64'(out_valid), 64'd0);
    checkOutput("clr_in_ready", 64'(in_ready), 64'd0);
    tick();
    checkOutput("clr_no_accept", 64'(busy), 64'd0);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    #1;
    checkOutput("clr_release_rdy", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | out_valid;
    end
    checkOutput("clr_no_output", 64'(seen), 64'd0);
    d = 64'hFEDC_BA98_7654_3210;
    applyStimulus(1'b1, d, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    checkOutput("post_clr_valid", 64'(out_valid), 64'd1);
    checkOutput("post_clr_data", out_data, loadVal(d) + 64'd16);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);

    $display("[TB] async reset mid-run");
    applyStimulus(1'b1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_mc_in", mc_in, 64'd0);
    checkOutput("arst_rk_idx", 64'(rk_idx), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | out_valid | busy;
    end
    checkOutput("arst_no_output", 64'(seen), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blink_round_ctrl.md
BLINK_ROUND_CTRL -- requirements
Module: blink_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 16, number of diffusion/add-key rounds per block (legal range 1..31).
REQ-002 Parameter RK_W, default 5, width of the round-key index, with 2^RK_W > ROUNDS.
REQ-003 Port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 Port clear, input, 1 bit, synchronous abort of any block in flight.
REQ-006 Port in_valid, input, 1 bit, a block is offered on in_data.
REQ-007 Port in_ready, output, 1 bit, the controller accepts in_data this cycle.
REQ-008 Port in_data, input, 64 bits, plaintext or intermediate state block.
REQ-009 Port rk_idx, output, RK_W bits, index of the round key currently requested.
REQ-010 Port rk_data, input, 64 bits, round key for rk_idx, valid combinationally in the same cycle.
REQ-011 Port mc_in, output, 64 bits, state driven into the external MixColumns_AddKey indata.
REQ-012 Port mc_key, output, 64 bits, key driven into the external MixColumns_AddKey key; equals rk_data.
REQ-013 Port mc_out, input, 64 bits, combinational result from MixColumns_AddKey outdata.
REQ-014 Port out_valid, output, 1 bit, out_data holds a finished block.
REQ-015 Port out_ready, input, 1 bit, the consumer takes out_data.
REQ-016 Port out_data, output, 64 bits, finished block, held stable while out_valid=1 and out_ready=0.
REQ-017 Port busy, output, 1 bit, high in RUN.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-019 The transition IDLE->RUN SHALL occur on in_valid & in_ready, loading state_reg <= in_data (whitened per REQ-032) and rnd <= 0.
REQ-020 In RUN, each cycle SHALL update state_reg <= mc_out and rnd <= rnd+1; when rnd = ROUNDS-1 the FSM SHALL go to DONE.
REQ-021 mc_in SHALL be state_reg at all times, and rk_idx SHALL be rnd + base, where base is 0 or 1 per REQ-032.
REQ-022 In DONE, out_valid=1 and out_data=state_reg; on out_ready the FSM SHALL go to IDLE, or straight to RUN if a new block is accepted in the same cycle.
REQ-023 in_ready SHALL be (state==IDLE) | (state==DONE & out_ready), with no combinational path from in_valid.
REQ-024 Latency SHALL be exactly ROUNDS+1 cycles from the accept edge to the first cycle with out_valid=1; back-to-back throughput SHALL be one block per ROUNDS+1 cycles.
REQ-025 When clear=1 in any state, the next state SHALL be IDLE, with out_valid dropping next cycle and the in-flight block discarded; clear SHALL take priority over all handshakes, and in_ready SHALL be 0 while clear=1.
REQ-026 in_valid while in RUN SHALL be ignored and not accepted.
REQ-027 out_valid, once set, SHALL stay 1 until out_ready=1 or clear=1.
REQ-028 The round counter SHALL never exceed ROUNDS-1, and no wrap-around SHALL occur.

Reset
REQ-029 While rst_n=0 the FSM SHALL be IDLE and rnd, state_reg, out_valid and busy SHALL be 0, with in_ready=1 combinationally after reset deassertion.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abort immediately, with no output produced for that block.
REQ-031 Reset deassertion is synchronised externally, so the block needs no internal synchroniser.

Configuration
REQ-032 Macro BLINK_ROUND_CTRL_WHITEN_EN controls key whitening:
- When defined: during the accept cycle rk_idx=0; the load is state_reg <= in_data ^ rk_data; rounds use rk_idx 1..ROUNDS (base=1).
- When undefined: the load is plain in_data; rounds use rk_idx 0..ROUNDS-1 (base=0); rk_idx=0 when not in RUN.

Verification
REQ-033 ROUNDS=2, all rk_data=0, in_data=0 -> out_valid at accept+3 cycles, out_data=64'h0.
REQ-034 ROUNDS=16, with mc_out stubbed as mc_in+1 -> rk_idx sequence 0..15 (1..16 with WHITEN_EN), out_data=in_data+16.
REQ-035 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, second in_valid not accepted.
REQ-036 out_ready=1 and in_valid=1 in the same DONE cycle -> new block accepted, RUN entered next cycle, no idle bubble.
REQ-037 clear pulsed at rnd=7 -> IDLE next cycle, out_valid never asserts for that block, next block completes correctly.
REQ-038 rst_n dropped asynchronously mid-RUN -> all outputs 0 within the same cycle, no out_valid after release.
